systemace_mpu_ctrl: RTL and testbench

- Parametrised low-level MPU-port controller for the SystemACE, successor to the fixed 16-bit single-access low-level interface.
- Sits between the SystemACE register/buffer driver and the chip pins.
- Adds:
  - configurable bus width and address width;
  - programmable setup, strobe and hold timing;
  - a valid/ready request channel with a separate response channel;
  - a synchronised BRDY input with timeout and error reporting for data-buffer accesses.

---
 rtl/systemace_mpu_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_systemace_mpu_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systemace_mpu_ctrl.sv
// SystemACE MPU-port controller: request/response front end driving the chip pins
// with programmable setup/strobe/hold timing and BRDY gating for data-buffer accesses.
module systemace_mpu_ctrl #(
  parameter int DW          = 16,
  parameter int AW          = 7,
  parameter int T_SETUP     = 1,
  parameter int T_STROBE    = 1,
  parameter int T_HOLD      = 1,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [AW-1:0] MPA,
  inout  wire  [DW-1:0] MPD,
  output logic          nMPCE,
  output logic          nMPWE,
  output logic          nMPOE,
  input  logic          MPBRDY,
  input  logic          MPIRQ,
  output logic          irq,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          req_isbuffer,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  localparam int CNT_MAX = (RDY_TIMEOUT > 15) ? RDY_TIMEOUT : 15;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'((T_HOLD > 0) ? T_HOLD - 1 : 0);
  localparam logic [CW-1:0] RDY_LAST    = CW'((RDY_TIMEOUT > 0) ? RDY_TIMEOUT - 1 : 0);
  localparam logic TO_EN   = (RDY_TIMEOUT != 0);
  localparam logic HOLD_EN = (T_HOLD != 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAITRDY = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [AW-1:0] mpa_r, mpa_s;
  logic          nce_r, nce_s, nwe_r, nwe_s, noe_r, noe_s;
  logic          drv_r, drv_s, write_r, write_s, isbuf_r, isbuf_s;
  logic [DW-1:0] wdata_r, wdata_s, rdata_r, rdata_s;
  logic          rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
  logic          brdy_meta_r, brdy_sync_r, irq_meta_r, irq_r;

  assign MPD       = drv_r ? wdata_r : {DW{1'bz}};
  assign MPA       = mpa_r;
  assign nMPCE     = nce_r;
  assign nMPWE     = nwe_r;
  assign nMPOE     = noe_r;
  assign irq       = irq_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = rsp_err_r;
  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);

  // Two-flop synchronisers for the asynchronous BRDY and IRQ pins
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      brdy_meta_r <= 1'b0;
      brdy_sync_r <= 1'b0;
      irq_meta_r  <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      brdy_meta_r <= MPBRDY;
      brdy_sync_r <= brdy_meta_r;
      irq_meta_r  <= MPIRQ;
      irq_r       <= irq_meta_r;
    end
  end

  // Next-state and next pin/response values; every pin changes with the state edge
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mpa_s       = mpa_r;
    nce_s       = nce_r;
    nwe_s       = nwe_r;
    noe_s       = noe_r;
    drv_s       = drv_r;
    wdata_s     = wdata_r;
    write_s     = write_r;
    isbuf_s     = isbuf_r;
    rdata_s     = rdata_r;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (req_valid) begin
          state_s = ST_SETUP;
          mpa_s   = req_addr;
          nce_s   = 1'b0;
          drv_s   = req_write;
          wdata_s = req_wdata;
          write_s = req_write;
          isbuf_s = req_isbuffer;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          cnt_s = CNT_ZERO;
          if (isbuf_r && !brdy_sync_r) begin
            state_s = ST_WAITRDY;
          end else begin
            state_s = ST_STROBE;
            noe_s   = write_r;
            nwe_s   = !write_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAITRDY: begin
        // A BRDY arriving on the final timeout cycle takes priority over the abort
        if (brdy_sync_r) begin
          state_s = ST_STROBE;
          cnt_s   = CNT_ZERO;
          noe_s   = write_r;
          nwe_s   = !write_r;
        end else if (TO_EN && (cnt_r == RDY_LAST)) begin
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
          nce_s       = 1'b1;
          drv_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          cnt_s = CNT_ZERO;
          nwe_s = 1'b1;
          noe_s = 1'b1;
          if (!write_r) begin
            rdata_s = MPD;
          end else begin
            rdata_s = rdata_r;
          end
          if (HOLD_EN) begin
            state_s = ST_HOLD;
          end else begin
            state_s     = ST_IDLE;
            nce_s       = 1'b1;
            drv_s       = 1'b0;
            rsp_valid_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
          nce_s       = 1'b1;
          drv_s       = 1'b0;
          rsp_valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        nce_s   = 1'b1;
        nwe_s   = 1'b1;
        noe_s   = 1'b1;
        drv_s   = 1'b0;
      end
    endcase
  end

  // State, counter, pin and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      mpa_r       <= {AW{1'b0}};
      nce_r       <= 1'b1;
      nwe_r       <= 1'b1;
      noe_r       <= 1'b1;
      drv_r       <= 1'b0;
      wdata_r     <= {DW{1'b0}};
      write_r     <= 1'b0;
      isbuf_r     <= 1'b0;
      rdata_r     <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mpa_r       <= mpa_s;
      nce_r       <= nce_s;
      nwe_r       <= nwe_s;
      noe_r       <= noe_s;
      drv_r       <= drv_s;
      wdata_r     <= wdata_s;
      write_r     <= write_s;
      isbuf_r     <= isbuf_s;
      rdata_r     <= rdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_systemace_mpu_ctrl.sv
// Self-checking bench for systemace_mpu_ctrl: instance A uses default timing with a
// memory-backed device model, instance B uses 2/3/0 timing with an 8-cycle BRDY timeout.
module tb_systemace_mpu_ctrl;
  localparam int DW = 16;
  localparam int AW = 7;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  logic [AW-1:0] mpa_a, mpa_b, req_addr_a, req_addr_b;
  wire  [DW-1:0] mpd_a, mpd_b;
  logic nce_a, nwe_a, noe_a, nce_b, nwe_b, noe_b;
  logic brdy_a = 1'b0, brdy_b = 1'b0, irqin_a = 1'b0, irqin_b = 1'b0, irq_a, irq_b;
  logic req_valid_a = 1'b0, req_valid_b = 1'b0, req_ready_a, req_ready_b;
  logic req_write_a = 1'b0, req_write_b = 1'b0, req_isbuf_a = 1'b0, req_isbuf_b = 1'b0;
  logic [DW-1:0] req_wdata_a, req_wdata_b, rsp_rdata_a, rsp_rdata_b;
  logic rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b, busy_a, busy_b;

  // Device A: power-on content is a fixed pattern per address, overwritten by strobed writes
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {1'b1, a, 8'h5A};
  endfunction
  logic [DW-1:0] dev_mem [128];
  bit   [127:0]  dev_wr;
  logic [DW-1:0] dev_rd_a;
  logic [DW-1:0] exp_mem [128];
  logic [DW-1:0] rd_val_b = 16'h1234;

  assign dev_rd_a = dev_wr[mpa_a] ? dev_mem[mpa_a] : pattern(mpa_a);
  // Devices drive zero while deselected so a controller that fails to release MPD is visible
  assign mpd_a = nce_a ? {DW{1'b0}} : (!noe_a ? dev_rd_a : {DW{1'bz}});
  assign mpd_b = nce_b ? {DW{1'b0}} : (!noe_b ? rd_val_b : {DW{1'bz}});

  always @(negedge CLK) begin
    if (!nwe_a && !nce_a) begin
      dev_mem[mpa_a] <= mpd_a;
      dev_wr[mpa_a]  <= 1'b1;
    end
  end

  systemace_mpu_ctrl #(.DW(DW), .AW(AW), .T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .RDY_TIMEOUT(1024)) u_a (
    .CLK(CLK), .RST(RST), .MPA(mpa_a), .MPD(mpd_a), .nMPCE(nce_a), .nMPWE(nwe_a), .nMPOE(noe_a),
    .MPBRDY(brdy_a), .MPIRQ(irqin_a), .irq(irq_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_isbuffer(req_isbuf_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a));

  systemace_mpu_ctrl #(.DW(DW), .AW(AW), .T_SETUP(2), .T_STROBE(3), .T_HOLD(0), .RDY_TIMEOUT(8)) u_b (
    .CLK(CLK), .RST(RST), .MPA(mpa_b), .MPD(mpd_b), .nMPCE(nce_b), .nMPWE(nwe_b), .nMPOE(noe_b),
    .MPBRDY(brdy_b), .MPIRQ(irqin_b), .irq(irq_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_isbuffer(req_isbuf_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b));

  // Issue one request on A and observe it until its response (64-cycle budget)
  task automatic run_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic isb,
                       input int rise_at, output logic [AW+DW:0] first, output int lat, output int we_lo,
                       output int oe_lo, output int stb_at, output logic [DW-1:0] rd, output logic er,
                       output logic rel);
    @(negedge CLK);
    req_write_a = w; req_addr_a = a; req_wdata_a = d; req_isbuf_a = isb; req_valid_a = 1'b1;
    @(posedge CLK); #1;
    req_valid_a = 1'b0;
    first = {mpa_a, nce_a, mpd_a};
    lat = -1; we_lo = 0; oe_lo = 0; stb_at = -1; rd = '0; er = 1'b0; rel = 1'b0;
    for (int c = 1; c <= 64 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (!nwe_a) we_lo++;
      if (!noe_a) oe_lo++;
      if (stb_at < 0 && (!nwe_a || !noe_a)) stb_at = c;
      if (rsp_valid_a) begin
        lat = c; rd = rsp_rdata_a; er = rsp_err_a; rel = nce_a && (mpd_a == 16'h0000);
      end
      if (c == rise_at) brdy_a = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if ({mpa_a, nce_a, nwe_a, noe_a, rsp_valid_a, rsp_err_a, irq_a, busy_a, req_ready_a} !== {7'h00, 8'b1110_0001}) begin
      n_fail++; $display("FAIL reset_pins_a: got %h expected %h", {mpa_a, nce_a, nwe_a, noe_a, rsp_valid_a, rsp_err_a, irq_a, busy_a, req_ready_a}, {7'h00, 8'b1110_0001});
    end
    n_tests++;
    if ({rsp_rdata_a, mpd_a} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data_a: rdata/MPD got %h expected 0 (MPD released)", {rsp_rdata_a, mpd_a});
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if ({nce_b, nwe_b, noe_b, busy_b, req_ready_b, rsp_valid_b} !== 6'b111010) begin
      n_fail++; $display("FAIL reset_pins_b: got %b expected 111010", {nce_b, nwe_b, noe_b, busy_b, req_ready_b, rsp_valid_b});
    end
  endtask

  task automatic test_irq();
    @(negedge CLK); irqin_a = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_sync1: got %b expected 0", irq_a); end
    @(posedge CLK); #1;
    n_tests++;
    if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_sync2: got %b expected 1", irq_a); end
    irqin_a = 1'b0;
  endtask

  task automatic test_write_default();
    logic [AW+DW:0] first; int lat, we, oe, stb; logic [DW-1:0] rd; logic er, rel;
    run_a(1'b1, 7'h12, 16'hA55A, 1'b0, -1, first, lat, we, oe, stb, rd, er, rel);
    exp_mem[7'h12] = 16'hA55A;
    n_tests++;
    if (first !== {7'h12, 1'b0, 16'hA55A}) begin n_fail++; $display("FAIL wr_first_edge: MPA/nCE/MPD got %h expected %h", first, {7'h12, 1'b0, 16'hA55A}); end
    n_tests++;
    if ({we, oe, stb} !== {32'd1, 32'd0, 32'd1}) begin n_fail++; $display("FAIL wr_strobe: we_lo=%0d oe_lo=%0d start=%0d expected 1 0 1", we, oe, stb); end
    n_tests++;
    if ({lat, er, rel} !== {32'd3, 1'b0, 1'b1}) begin n_fail++; $display("FAIL wr_rsp: lat=%0d err=%b released=%b expected 3 0 1", lat, er, rel); end
    run_a(1'b0, 7'h12, 16'h0000, 1'b0, -1, first, lat, we, oe, stb, rd, er, rel);
    n_tests++;
    if (rd !== 16'hA55A) begin n_fail++; $display("FAIL wr_readback: got %h expected a55a", rd); end
  endtask

  task automatic test_read_timing();
    int lat = -1, oe = 0, we = 0, bad = 0;
    @(negedge CLK);
    req_write_b = 1'b0; req_addr_b = 7'h05; req_wdata_b = 16'hEDCB; req_isbuf_b = 1'b0; req_valid_b = 1'b1;
    @(posedge CLK); #1;
    req_valid_b = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (!noe_b) oe++;
      if (!nwe_b) we++;
      if (nce_b ? (mpd_b != 16'h0000) : (!noe_b && mpd_b != 16'h1234)) bad++;
      if (rsp_valid_b) lat = c;
    end
    n_tests++;
    if ({lat, oe, we} !== {32'd5, 32'd3, 32'd0}) begin n_fail++; $display("FAIL rd_timing: lat=%0d oe_lo=%0d we_lo=%0d expected 5 3 0", lat, oe, we); end
    n_tests++;
    if ({rsp_rdata_b, rsp_err_b} !== {16'h1234, 1'b0}) begin n_fail++; $display("FAIL rd_data: got %h err=%b expected 1234 0", rsp_rdata_b, rsp_err_b); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rd_mpd_drive: %0d contended samples expected 0", bad); end
  endtask

  task automatic test_timeout();
    int lat = -1, we = 0;
    logic er = 1'b0;
    @(negedge CLK);
    req_write_b = 1'b1; req_addr_b = 7'h40; req_wdata_b = 16'h5AA5; req_isbuf_b = 1'b1; req_valid_b = 1'b1;
    @(posedge CLK); #1;
    req_valid_b = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (!nwe_b) we++;
      if (rsp_valid_b) begin lat = c; er = rsp_err_b; end
    end
    n_tests++;
    if ({lat, we, er} !== {32'd10, 32'd0, 1'b1}) begin n_fail++; $display("FAIL timeout_rsp: lat=%0d we_lo=%0d err=%b expected 10 0 1", lat, we, er); end
    n_tests++;
    if ({nce_b, busy_b, mpd_b, rsp_rdata_b} !== {1'b1, 1'b0, 16'h0000, 16'h1234}) begin
      n_fail++; $display("FAIL timeout_release: nCE=%b busy=%b MPD=%h rdata=%h expected 1 0 0000 1234", nce_b, busy_b, mpd_b, rsp_rdata_b);
    end
  endtask

  task automatic test_buffer_wait();
    logic [AW+DW:0] first; int lat, we, oe, stb; logic [DW-1:0] rd; logic er, rel;
    logic [AW-1:0] a = AW'($urandom_range(0, 127));
    brdy_a = 1'b0;
    repeat (3) @(posedge CLK);
    run_a(1'b0, a, 16'h0000, 1'b1, 10, first, lat, we, oe, stb, rd, er, rel);
    // BRDY raised after edge 10: two synchroniser edges, then the strobe edge
    n_tests++;
    if ({stb, oe, we} !== {32'd13, 32'd1, 32'd0}) begin n_fail++; $display("FAIL bufwait_strobe: start=%0d oe_lo=%0d we_lo=%0d expected 13 1 0", stb, oe, we); end
    n_tests++;
    if ({lat, er, rd} !== {32'd15, 1'b0, exp_mem[a]}) begin n_fail++; $display("FAIL bufwait_rsp: lat=%0d err=%b rd=%h expected 15 0 %h", lat, er, rd, exp_mem[a]); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a0 = AW'($urandom_range(0, 63));
    logic [DW-1:0] d0 = DW'($urandom_range(1, 65535)), d1 = DW'($urandom_range(1, 65535));
    logic          w  [4];
    logic [AW-1:0] ad [4];
    logic [DW-1:0] dd [4];
    int idx = 0, resp = 0, extra = 0;
    logic acc;
    w = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad = '{a0, a0, a0 + 7'd64, a0 + 7'd64};
    dd = '{d0, 16'h0000, d1, 16'h0000};
    @(posedge CLK); #1;
    req_write_a = w[0]; req_addr_a = ad[0]; req_wdata_a = dd[0]; req_isbuf_a = 1'b0; req_valid_a = 1'b1;
    for (int c = 0; c < 60 && resp < 4; c++) begin
      @(negedge CLK);
      if (rsp_valid_a) begin
        n_tests++;
        if ({rsp_err_a, (resp < 3) ? req_ready_a : 1'b1} !== 2'b01) begin
          n_fail++; $display("FAIL b2b_accept_%0d: err=%b ready=%b expected 0 1", resp, rsp_err_a, req_ready_a);
        end
        if (!w[resp]) begin
          n_tests++;
          if (rsp_rdata_a !== dd[resp-1]) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h expected %h", resp, rsp_rdata_a, dd[resp-1]); end
        end
        resp++;
      end
      acc = req_valid_a && req_ready_a;
      @(posedge CLK); #1;
      if (acc) begin
        if (w[idx]) exp_mem[ad[idx]] = dd[idx];
        idx++;
        if (idx < 4) begin
          req_write_a = w[idx]; req_addr_a = ad[idx]; req_wdata_a = dd[idx];
        end else begin
          req_valid_a = 1'b0;
        end
      end
    end
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid_a) extra++;
    end
    n_tests++;
    if ({resp, extra} !== {32'd4, 32'd0}) begin n_fail++; $display("FAIL b2b_count: responses=%0d extra=%0d expected 4 0", resp, extra); end
  endtask

  task automatic test_random();
    logic [AW+DW:0] first; int lat, we, oe, stb; logic [DW-1:0] rd; logic er, rel;
    logic w, isb; logic [AW-1:0] a; logic [DW-1:0] d;
    brdy_a = 1'b1;
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1)); isb = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7)); d = DW'($urandom_range(1, 65535));
      run_a(w, a, d, isb, -1, first, lat, we, oe, stb, rd, er, rel);
      n_tests++;
      if ({lat, we, oe, er, rel, first[AW+DW:DW]} !== {32'd3, w ? 32'd1 : 32'd0, w ? 32'd0 : 32'd1, 1'b0, 1'b1, a, 1'b0}) begin
        n_fail++; $display("FAIL rand_%0d_timing: lat=%0d we=%0d oe=%0d err=%b rel=%b mpa=%h w=%b", i, lat, we, oe, er, rel, first[AW+DW:DW+1], w);
      end
      if (w) begin
        exp_mem[a] = d;
      end else begin
        n_tests++;
        if (rd !== exp_mem[a]) begin n_fail++; $display("FAIL rand_%0d_rdata: addr %h got %h expected %h", i, a, rd, exp_mem[a]); end
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW+DW:0] first; int lat, we, oe, stb, spurious = 0; logic [DW-1:0] rd; logic er, rel;
    @(negedge CLK);
    req_write_a = 1'b1; req_addr_a = 7'h33; req_wdata_a = 16'h0F0F; req_isbuf_a = 1'b0; req_valid_a = 1'b1;
    @(posedge CLK); #1;
    req_valid_a = 1'b0;
    @(posedge CLK); #1;
    n_tests++;
    if (nwe_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_strobe: nMPWE got %b expected 0", nwe_a); end
    RST = 1'b0;
    #1;
    n_tests++;
    if ({nce_a, nwe_a, noe_a, busy_a, rsp_valid_a, mpd_a} !== {5'b11100, 16'h0000}) begin
      n_fail++; $display("FAIL rstmid_abort: got %h expected %h", {nce_a, nwe_a, noe_a, busy_a, rsp_valid_a, mpd_a}, {5'b11100, 16'h0000});
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      if (rsp_valid_a) spurious++;
    end
    n_tests++;
    if (spurious != 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", spurious); end
    run_a(1'b0, 7'h33, 16'h0000, 1'b0, -1, first, lat, we, oe, stb, rd, er, rel);
    n_tests++;
    if ({lat, rd} !== {32'd3, exp_mem[7'h33]}) begin n_fail++; $display("FAIL rstmid_aborted_write: lat=%0d rd=%h expected 3 %h", lat, rd, exp_mem[7'h33]); end
    run_a(1'b1, 7'h33, 16'hC3C3, 1'b0, -1, first, lat, we, oe, stb, rd, er, rel);
    run_a(1'b0, 7'h33, 16'h0000, 1'b0, -1, first, lat, we, oe, stb, rd, er, rel);
    n_tests++;
    if ({lat, er, rd} !== {32'd3, 1'b0, 16'hC3C3}) begin n_fail++; $display("FAIL rstmid_recover: lat=%0d err=%b rd=%h expected 3 0 c3c3", lat, er, rd); end
  endtask

  initial begin
    req_addr_a = '0; req_wdata_a = '0; req_addr_b = '0; req_wdata_b = '0;
    for (int i = 0; i < 128; i++) exp_mem[i] = pattern(AW'(i));
    test_reset();
    test_irq();
    test_write_default();
    test_read_timing();
    test_timeout();
    test_buffer_wait();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
